// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter: baud divisors, line-control
// field positions, the frame state enum and small decode/parity helpers.
package uart_pkg;

  // Clocks per 16x sample tick at 18.432 MHz.
  localparam logic [6:0] DIV_9600   = 7'd120;
  localparam logic [6:0] DIV_19200  = 7'd60;
  localparam logic [6:0] DIV_38400  = 7'd30;
  localparam logic [6:0] DIV_115200 = 7'd10;

  localparam int LCR_WLEN_LSB = 0;
  localparam int LCR_STOP2    = 2;
  localparam int LCR_PAR_EN   = 3;
  localparam int LCR_PAR_EVEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic logic [6:0] baud_div(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_9600;
      2'b01:   return DIV_19200;
      2'b10:   return DIV_38400;
      2'b11:   return DIV_115200;
      default: return DIV_115200;
    endcase
  endfunction

  function automatic logic [3:0] word_len(input logic [1:0] wl);
    case (wl)
      2'b00:   return 4'd8;
      2'b01:   return 4'd7;
      2'b10:   return 4'd6;
      2'b11:   return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  // acc is the XOR of the data bits; even parity expects acc^par == 0, odd expects 1.
  function automatic logic parity_error(input logic acc, input logic par_bit, input logic even);
    return even ? (acc ^ par_bit) : ~(acc ^ par_bit);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: one-cycle tick every baud_div(baud_sel) clocks while enabled,
// restarted by clear so the first tick lands a full divisor after the clear.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  logic [6:0] div_s;
  logic [6:0] cnt_r;
  logic       tick_r;

  assign div_s = baud_div(baud_sel);
  assign tick  = tick_r;

  // Divisor counter; tick_r is raised one clock early so it is valid in the cycle the count wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= 7'd0;
      tick_r <= 1'b0;
    end else if (clear || !enable) begin
      cnt_r  <= 7'd0;
      tick_r <= 1'b0;
    end else if (cnt_r == (div_s - 7'd1)) begin
      cnt_r  <= 7'd0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + 7'd1;
      tick_r <= (cnt_r == (div_s - 7'd2));
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronises rx_serial, oversamples 16x and deframes start/data/parity/stop
// according to the line-control word latched at the start edge.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 18432000,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [4:0] line_control_reg,
  input  logic       rx_serial,
  output logic [7:0] data_received,
  output logic       data_corrupted_flag,
  output logic       active_flag_rx,
  output logic       transmission_done_flag
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  if (CLK_FREQ_HZ != 18432000 || OVERSAMPLE != 16 || SYNC_STAGES < 2) begin : g_cfg_check
    $error("uart_rx_frame: divisor table only valid for 18.432 MHz, 16x, >=2 sync stages");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_prev_r;
  uart_state_e            state_r;
  logic [1:0]             baud_r;
  logic [4:0]             lcr_r;
  logic [3:0]             os_cnt_r;
  logic [2:0]             bit_idx_r;
  logic                   stop_idx_r;
  logic [7:0]             data_r;
  logic                   par_acc_r;
  logic                   par_err_r;
  logic                   frame_err_r;
  logic [7:0]             data_received_r;
  logic                   corrupted_r;
  logic                   active_r;
  logic                   done_r;

  logic rx_s;
  logic fall_s;
  logic tick_s;
  logic tick_en_s;
  logic sample_s;
  logic last_data_s;
  logic last_stop_s;
  logic frame_end_s;
  logic start_s;

  assign rx_s        = sync_r[SYNC_STAGES-1];
  assign fall_s      = rx_prev_r & ~rx_s;
  assign tick_en_s   = (state_r != ST_IDLE);
  assign sample_s    = tick_s & (os_cnt_r == MID_TICK);
  assign last_data_s = ({1'b0, bit_idx_r} == (word_len(lcr_r[LCR_WLEN_LSB +: 2]) - 4'd1));
  assign last_stop_s = ~lcr_r[LCR_STOP2] | stop_idx_r;
  assign frame_end_s = (state_r == ST_STOP) & sample_s & last_stop_s;
  // A start edge coinciding with frame end is honoured so back-to-back frames are not lost.
  assign start_s     = fall_s & ((state_r == ST_IDLE) | frame_end_s);

  assign data_received          = data_received_r;
  assign data_corrupted_flag    = corrupted_r;
  assign active_flag_rx         = active_r;
  assign transmission_done_flag = done_r;

  uart_baud_tick u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_sel (baud_r),
    .enable   (tick_en_s),
    .clear    (start_s),
    .tick     (tick_s)
  );

  // Synchroniser, frame FSM, shift register, parity accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r          <= {SYNC_STAGES{1'b1}};
      rx_prev_r       <= 1'b1;
      state_r         <= ST_IDLE;
      baud_r          <= 2'b00;
      lcr_r           <= 5'd0;
      os_cnt_r        <= 4'd0;
      bit_idx_r       <= 3'd0;
      stop_idx_r      <= 1'b0;
      data_r          <= 8'd0;
      par_acc_r       <= 1'b0;
      par_err_r       <= 1'b0;
      frame_err_r     <= 1'b0;
      data_received_r <= 8'd0;
      corrupted_r     <= 1'b0;
      active_r        <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], rx_serial};
      rx_prev_r <= rx_s;
      done_r    <= 1'b0;

      if (tick_s) begin
        os_cnt_r <= (os_cnt_r == LAST_TICK) ? 4'd0 : os_cnt_r + 4'd1;
      end

      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_START: begin
          if (sample_s) begin
            if (!rx_s) begin
              state_r   <= ST_DATA;
              active_r  <= 1'b1;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (sample_s) begin
            data_r[bit_idx_r] <= rx_s;
            par_acc_r         <= par_acc_r ^ rx_s;
            if (last_data_s) begin
              state_r    <= lcr_r[LCR_PAR_EN] ? ST_PARITY : ST_STOP;
              stop_idx_r <= 1'b0;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_s) begin
            par_err_r <= parity_error(par_acc_r, rx_s, lcr_r[LCR_PAR_EVEN]);
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (frame_end_s) begin
            data_received_r <= data_r;
            corrupted_r     <= par_err_r | frame_err_r | ~rx_s;
            done_r          <= 1'b1;
            active_r        <= 1'b0;
            state_r         <= rx_s ? ST_IDLE : ST_BREAK;
          end else if (sample_s) begin
            frame_err_r <= frame_err_r | ~rx_s;
            stop_idx_r  <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // New frame: latch config and clear per-frame state, overriding the case above.
      if (start_s) begin
        state_r     <= ST_START;
        baud_r      <= baud_sel;
        lcr_r       <= line_control_reg;
        os_cnt_r    <= 4'd0;
        bit_idx_r   <= 3'd0;
        stop_idx_r  <= 1'b0;
        data_r      <= 8'd0;
        par_acc_r   <= 1'b0;
        par_err_r   <= 1'b0;
        frame_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed vector table, glitch/reset/back-to-back
// sequences and randomized frames checked against a rule-level frame model.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic [4:0] line_control_reg;
  logic       rx_serial;
  logic [7:0] data_received;
  logic       data_corrupted_flag;
  logic       active_flag_rx;
  logic       transmission_done_flag;

  always #5 clk = ~clk;

  uart_rx_frame dut (
    .clk                    (clk),
    .rst                    (rst),
    .baud_sel               (baud_sel),
    .line_control_reg       (line_control_reg),
    .rx_serial              (rx_serial),
    .data_received          (data_received),
    .data_corrupted_flag    (data_corrupted_flag),
    .active_flag_rx         (active_flag_rx),
    .transmission_done_flag (transmission_done_flag)
  );

  typedef struct {
    logic [7:0] data;
    logic       corrupt;
    int         at;
  } obs_t;

  typedef struct {
    logic [1:0] baud;
    logic [4:0] lcr;
    logic [7:0] data;
    bit         flip;
    logic [1:0] stop_low;
    logic [7:0] exp_data;
    bit         exp_corr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   obs_n = 0;
  int   active_cnt = 0;
  int   fall_cyc = 0;
  obs_t obs_arr[64];
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle the done flag is high, with the outputs seen alongside it.
  always @(negedge clk) begin
    if (transmission_done_flag === 1'b1 && obs_n < 64) begin
      obs_arr[obs_n] <= '{data_received, data_corrupted_flag, cyc};
      obs_n          <= obs_n + 1;
    end
    if (active_flag_rx === 1'b1) active_cnt <= active_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int divisor(input logic [1:0] b);
    case (b)
      2'b00:   return 120;
      2'b01:   return 60;
      2'b10:   return 30;
      default: return 10;
    endcase
  endfunction

  function automatic int nbits(input logic [4:0] lcr);
    return 8 - int'(lcr[1:0]);
  endfunction

  function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [4:0] lcr);
    logic [8:0] m;
    m = (9'd1 << nbits(lcr)) - 9'd1;
    return d & m[7:0];
  endfunction

  // Bits after the start bit up to and including the last stop bit.
  function automatic int frame_bits(input logic [4:0] lcr);
    return nbits(lcr) + (lcr[3] ? 1 : 0) + (lcr[2] ? 2 : 1);
  endfunction

  function automatic logic good_parity(input logic [7:0] dm, input logic even);
    return even ? (^dm) : ~(^dm);
  endfunction

  function automatic logic model_corrupt(input logic [4:0] lcr, input bit flip, input logic [1:0] sl);
    return (lcr[3] & flip) | sl[0] | (lcr[2] & sl[1]);
  endfunction

  task automatic bit_time(input logic [1:0] b);
    repeat (16 * divisor(b)) @(negedge clk);
  endtask

  // Drive one frame starting at a negedge; config is scrambled after the start bit.
  task automatic send_frame(input logic [1:0] b, input logic [4:0] lcr, input logic [7:0] d,
                            input bit flip, input logic [1:0] sl, input bit scramble);
    logic [7:0] dm;
    dm = mask_data(d, lcr);
    baud_sel = b;
    line_control_reg = lcr;
    rx_serial = 1'b0;
    fall_cyc = cyc;
    bit_time(b);
    if (scramble) begin
      baud_sel = 2'($urandom);
      line_control_reg = 5'($urandom);
    end
    for (int i = 0; i < nbits(lcr); i++) begin
      rx_serial = dm[i];
      bit_time(b);
    end
    if (lcr[3]) begin
      rx_serial = good_parity(dm, lcr[4]) ^ flip;
      bit_time(b);
    end
    rx_serial = ~sl[0];
    bit_time(b);
    if (lcr[2]) begin
      rx_serial = ~sl[1];
      bit_time(b);
    end
    rx_serial = 1'b1;
  endtask

  task automatic wait_obs(input string name, input int want);
    for (int i = 0; i < 400 && obs_n < want; i++) @(negedge clk);
    check({name, "_pulse_seen"}, (obs_n >= want), 1'b1);
  endtask

  task automatic run_frame(input string name, input logic [1:0] b, input logic [4:0] lcr,
                           input logic [7:0] d, input bit flip, input logic [1:0] sl,
                           input logic [7:0] exp_d, input bit exp_c);
    int want;
    int lat_l;
    want = obs_n + 1;
    lat_l = 8 * divisor(b) * (2 * frame_bits(lcr) + 1);
    send_frame(b, lcr, d, flip, sl, 1'b1);
    wait_obs(name, want);
    if (obs_n >= want) begin
      check({name, "_data"}, obs_arr[want-1].data, exp_d);
      check({name, "_corrupt"}, obs_arr[want-1].corrupt, exp_c);
      check_range({name, "_latency"}, obs_arr[want-1].at - fall_cyc, lat_l + 1, lat_l + 4);
    end
    repeat (20) @(negedge clk);
    check({name, "_pulse_count"}, obs_n, want);
    check({name, "_active_after"}, active_flag_rx, 1'b0);
  endtask

  initial begin
    int a0;
    int act0;
    logic [4:0] r_lcr;
    logic [7:0] r_d;
    bit         r_flip;
    logic [1:0] r_sl;

    vecs[0] = '{2'b11, 5'b00000, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0};
    vecs[1] = '{2'b00, 5'b11000, 8'h55, 1'b0, 2'b00, 8'h55, 1'b0};
    vecs[2] = '{2'b00, 5'b11000, 8'h55, 1'b1, 2'b00, 8'h55, 1'b1};
    vecs[3] = '{2'b01, 5'b00011, 8'h1D, 1'b0, 2'b00, 8'h1D, 1'b0};
    vecs[4] = '{2'b11, 5'b00100, 8'hE2, 1'b0, 2'b10, 8'hE2, 1'b1};
    vecs[5] = '{2'b11, 5'b01001, 8'hC3, 1'b0, 2'b00, 8'h43, 1'b0};
    vecs[6] = '{2'b11, 5'b00010, 8'hFF, 1'b0, 2'b01, 8'h3F, 1'b1};

    rst = 1'b0;
    rx_serial = 1'b1;
    baud_sel = 2'b11;
    line_control_reg = 5'd0;
    repeat (5) @(negedge clk);
    check("reset_data", data_received, 8'h00);
    check("reset_corrupt", data_corrupted_flag, 1'b0);
    check("reset_active", active_flag_rx, 1'b0);
    check("reset_done", transmission_done_flag, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].baud, vecs[v].lcr, vecs[v].data,
                vecs[v].flip, vecs[v].stop_low, vecs[v].exp_data, vecs[v].exp_corr);
    end

    // Short low glitch must be rejected at the start-bit mid-point.
    baud_sel = 2'b11;
    line_control_reg = 5'd0;
    a0 = obs_n;
    act0 = active_cnt;
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_done", obs_n, a0);
    check("glitch_no_active", active_cnt, act0);
    run_frame("after_glitch_6d", 2'b11, 5'b00000, 8'h6D, 1'b0, 2'b00, 8'h6D, 1'b0);

    // Reset in the middle of the data bits discards the frame.
    a0 = obs_n;
    fork
      send_frame(2'b11, 5'b00000, 8'hFF, 1'b0, 2'b00, 1'b0);
      begin
        repeat (800) @(negedge clk);
        check("midrst_active_before", active_flag_rx, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_data", data_received, 8'h00);
        check("midrst_corrupt", data_corrupted_flag, 1'b0);
        check("midrst_active", active_flag_rx, 1'b0);
        check("midrst_done", transmission_done_flag, 1'b0);
        @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("midrst_no_done", obs_n, a0);
    run_frame("after_rst_7f", 2'b11, 5'b00000, 8'h7F, 1'b0, 2'b00, 8'h7F, 1'b0);

    // Back-to-back frames with no idle time between stop and next start.
    a0 = obs_n;
    send_frame(2'b11, 5'b00000, 8'h01, 1'b0, 2'b00, 1'b1);
    send_frame(2'b11, 5'b00000, 8'h80, 1'b0, 2'b00, 1'b1);
    wait_obs("b2b", a0 + 2);
    if (obs_n >= a0 + 2) begin
      check("b2b_first_data", obs_arr[a0].data, 8'h01);
      check("b2b_first_corrupt", obs_arr[a0].corrupt, 1'b0);
      check("b2b_second_data", obs_arr[a0+1].data, 8'h80);
      check("b2b_second_corrupt", obs_arr[a0+1].corrupt, 1'b0);
    end
    repeat (20) @(negedge clk);
    check("b2b_pulse_count", obs_n, a0 + 2);

    // Randomized frames against the rule-level model.
    for (int k = 0; k < 6; k++) begin
      r_lcr  = 5'($urandom_range(0, 31));
      r_d    = 8'($urandom);
      r_flip = ($urandom_range(0, 3) == 0);
      r_sl   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_frame($sformatf("rand%0d", k), 2'b11, r_lcr, r_d, r_flip, r_sl,
                mask_data(r_d, r_lcr), model_corrupt(r_lcr, r_flip, r_sl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
